// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: latch enables, flushes, sticky halt
// and saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dren,
  input  logic             mem_dwen,
  input  logic             mem_halt,
  input  logic             ex_dren,
  input  logic [REG_W-1:0] ex_wsel,
  input  logic [REG_W-1:0] id_rsel1,
  input  logic [REG_W-1:0] id_rsel2,
  input  logic             id_uses_rt,
  input  logic             ex_redirect,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, HALT} state_t;

  state_t state;

  logic freeze;
  logic load_use;
  logic r_halted;
  logic r_freeze;
  logic r_halt;
  logic r_redir;
  logic r_lu;

  assign freeze = ((mem_dren | mem_dwen) & ~dhit) | ~ihit;

  assign load_use = ex_dren && (ex_wsel != '0) &&
                    ((ex_wsel == id_rsel1) ||
                     (id_uses_rt && (ex_wsel == id_rsel2)));

  // Rule priority flattened into mutually exclusive selects
  assign r_halted = (state == HALT);
  assign r_freeze = ~r_halted & freeze;
  assign r_halt   = ~r_halted & ~freeze & mem_halt;
  assign r_redir  = ~r_halted & ~freeze & ~mem_halt & ex_redirect;
  assign r_lu     = ~r_halted & ~freeze & ~mem_halt & ~ex_redirect
                    & load_use;

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    unique case (1'b1)
      r_halted, r_freeze: ;
      r_halt: mem_wb_en = 1'b1;
      r_redir: begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end
      r_lu: begin
        id_ex_en    = 1'b1;
        id_ex_flush = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
      end
      default: begin
        pc_en     = 1'b1;
        if_id_en  = 1'b1;
        id_ex_en  = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= RUN;
      halt_o    <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (r_halt) begin
        state  <= HALT;
        halt_o <= 1'b1;
      end
      if (!r_halted && !pc_en && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (r_redir && flush_cnt != '1)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expectations,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  logic             CLK;
  logic             nRST;
  logic             ihit, dhit;
  logic             mem_dren, mem_dwen, mem_halt;
  logic             ex_dren;
  logic [REG_W-1:0] ex_wsel, id_rsel1, id_rsel2;
  logic             id_uses_rt, ex_redirect;
  logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic             if_id_flush, id_ex_flush, halt_o;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  typedef struct {
    string            name;
    logic [4:0]       en;
    logic [1:0]       fl;
    logic             h;
    logic [CNT_W-1:0] s;
    logic [CNT_W-1:0] f;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .nRST(nRST),
    .ihit(ihit), .dhit(dhit),
    .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_halt(mem_halt),
    .ex_dren(ex_dren), .ex_wsel(ex_wsel),
    .id_rsel1(id_rsel1), .id_rsel2(id_rsel2),
    .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halt_o(halt_o), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Monitor: outputs are valid every cycle an expectation is pending
  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [4:0] a_en;
      logic [1:0] a_fl;
      e    = q.pop_front();
      a_en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
      a_fl = {if_id_flush, id_ex_flush};
      n_checks++;
      if (a_en !== e.en || a_fl !== e.fl || halt_o !== e.h ||
          stall_cnt !== e.s || flush_cnt !== e.f) begin
        n_fail++;
        $display("FAIL %s: got en=%b fl=%b h=%b s=%0d f=%0d want en=%b fl=%b h=%b s=%0d f=%0d",
                 e.name, a_en, a_fl, halt_o, stall_cnt, flush_cnt,
                 e.en, e.fl, e.h, e.s, e.f);
      end
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
    ihit        = 1'b1;
    dhit        = 1'b1;
    mem_dren    = 1'b0;
    mem_dwen    = 1'b0;
    mem_halt    = 1'b0;
    ex_dren     = 1'b0;
    ex_wsel     = '0;
    id_rsel1    = '0;
    id_rsel2    = '0;
    id_uses_rt  = 1'b0;
    ex_redirect = 1'b0;
  endtask

  task automatic expect_now(input string n, input logic [4:0] en,
                            input logic [1:0] fl, input logic h,
                            input int s, input int f);
    exp_t e;
    e.name = n;
    e.en   = en;
    e.fl   = fl;
    e.h    = h;
    e.s    = CNT_W'(s);
    e.f    = CNT_W'(f);
    q.push_back(e);
  endtask

  initial begin
    nRST = 1'b0;
    cyc(); expect_now("reset", 5'b11111, 2'b00, 0, 0, 0);
    cyc(); nRST = 1'b1;
    expect_now("idle0", 5'b11111, 2'b00, 0, 0, 0);
    cyc(); expect_now("idle1", 5'b11111, 2'b00, 0, 0, 0);

    cyc(); ex_dren = 1; ex_wsel = 8; id_rsel1 = 8;
    expect_now("lu_rs", 5'b00111, 2'b01, 0, 0, 0);
    cyc(); expect_now("after_lu", 5'b11111, 2'b00, 0, 1, 0);
    cyc(); ex_dren = 1; ex_wsel = 0; id_rsel1 = 0;
    expect_now("lu_r0", 5'b11111, 2'b00, 0, 1, 0);
    cyc(); ex_dren = 1; ex_wsel = 9; id_rsel2 = 9; id_uses_rt = 1;
    id_rsel1 = 3;
    expect_now("lu_rt", 5'b00111, 2'b01, 0, 1, 0);
    cyc(); ex_dren = 1; ex_wsel = 9; id_rsel2 = 9; id_rsel1 = 3;
    expect_now("rt_unused", 5'b11111, 2'b00, 0, 2, 0);

    for (int i = 0; i < 3; i++) begin
      cyc(); mem_dren = 1; dhit = 0;
      expect_now("dwait", 5'b00000, 2'b00, 0, 2 + i, 0);
    end
    cyc(); expect_now("dwait_end", 5'b11111, 2'b00, 0, 5, 0);

    cyc(); ex_redirect = 1; ex_dren = 1; ex_wsel = 8; id_rsel1 = 8;
    expect_now("redir_lu", 5'b11111, 2'b11, 0, 5, 0);
    cyc(); expect_now("after_redir", 5'b11111, 2'b00, 0, 5, 1);
    cyc(); ihit = 0;
    expect_now("iwait", 5'b00000, 2'b00, 0, 5, 1);
    cyc(); mem_dwen = 1; dhit = 0;
    expect_now("swait", 5'b00000, 2'b00, 0, 6, 1);
    cyc(); mem_halt = 1; ihit = 0;
    expect_now("halt_frz", 5'b00000, 2'b00, 0, 7, 1);
    cyc(); mem_halt = 1;
    expect_now("halt", 5'b00001, 2'b00, 0, 8, 1);
    cyc(); expect_now("halted", 5'b00000, 2'b00, 1, 9, 1);
    cyc(); ex_redirect = 1;
    expect_now("halted_hold", 5'b00000, 2'b00, 1, 9, 1);

    cyc(); nRST = 1'b0;
    expect_now("async_rst", 5'b11111, 2'b00, 0, 0, 0);
    cyc(); nRST = 1'b1;
    expect_now("rst_rel", 5'b11111, 2'b00, 0, 0, 0);

    for (int i = 0; i < (1 << CNT_W) + 5; i++) begin
      cyc(); ihit = 0;
      expect_now("sat", 5'b00000, 2'b00, 0,
                 (i > 15) ? 15 : i, 0);
    end
    cyc(); expect_now("sat_hold", 5'b11111, 2'b00, 0, 15, 0);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d pending, want 0", q.size());
    end
    @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
